top_start_seq: RTL and testbench

Register-domain sequencer that orders start, stop and 32 kHz clock-source changes for the measurement top. It turns single-cycle request pulses from reg_ctrl into the level controls `rg_fifo_clk_en`, `rg_top_start` and `rg_clk_sel` consumed by crgu. It guarantees three things: the FIFO clock runs before the top starts, the FIFO drains before its clock is gated, and the 32 kHz source only switches while the top is idle, with a settle window afterwards.

---
 rtl/top_start_seq.sv | 167 ++++++++++++++++
 tb/tb_top_start_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/top_start_seq.sv
// Register-domain start/stop/clock-select sequencer for the measurement top.
// Turns request pulses into ordered level controls for crgu.
module top_start_seq #(
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned FIFO_LEAD = 8,
  parameter int unsigned DRAIN_CYC = 16,
  parameter int unsigned CLKSW_CYC = 1024
) (
  input  logic       clk_6p5m_reg,
  input  logic       rst_reg_n,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       clk_sel_req,
  input  logic       clk_sel_val,
  output logic       rg_top_start,
  output logic       rg_fifo_clk_en,
  output logic       rg_clk_sel,
  output logic       busy,
  output logic [2:0] state,
  output logic       evt_started,
  output logic       evt_stopped,
  output logic       req_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FIFO_ON = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_CLK_SW  = 3'd4;

  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(FIFO_LEAD - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CLKSW_LAST = CNT_W'(CLKSW_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             top_start_q, top_start_d;
  logic             fifo_clk_en_q, fifo_clk_en_d;
  logic             clk_sel_q, clk_sel_d;
  logic             busy_q, busy_d;
  logic             evt_started_q, evt_started_d;
  logic             evt_stopped_q, evt_stopped_d;
  logic             req_err_q, req_err_d;

  // State register and registered outputs.
  always_ff @(posedge clk_6p5m_reg or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      top_start_q   <= 1'b0;
      fifo_clk_en_q <= 1'b0;
      clk_sel_q     <= 1'b0;
      busy_q        <= 1'b0;
      evt_started_q <= 1'b0;
      evt_stopped_q <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      top_start_q   <= top_start_d;
      fifo_clk_en_q <= fifo_clk_en_d;
      clk_sel_q     <= clk_sel_d;
      busy_q        <= busy_d;
      evt_started_q <= evt_started_d;
      evt_stopped_q <= evt_stopped_d;
      req_err_q     <= req_err_d;
    end
  end

  // Next-state logic; priority is stop > clk_sel > start, losers flag req_err.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    top_start_d   = top_start_q;
    fifo_clk_en_d = fifo_clk_en_q;
    clk_sel_d     = clk_sel_q;
    evt_started_d = 1'b0;
    evt_stopped_d = 1'b0;
    req_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (stop_req) begin
          req_err_d = clk_sel_req | start_req;
        end else if (clk_sel_req) begin
          req_err_d = start_req;
          if (clk_sel_val != clk_sel_q) begin
            clk_sel_d = clk_sel_val;
            cnt_d     = '0;
            state_d   = ST_CLK_SW;
          end
        end else if (start_req) begin
          fifo_clk_en_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_FIFO_ON;
        end
      end

      ST_FIFO_ON: begin
        req_err_d = start_req | clk_sel_req;
        if (stop_req) begin
          fifo_clk_en_d = 1'b0;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else if (cnt_q == LEAD_LAST) begin
          top_start_d   = 1'b1;
          evt_started_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        req_err_d = start_req | clk_sel_req;
        if (stop_req) begin
          top_start_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        req_err_d = start_req | clk_sel_req | stop_req;
        if (cnt_q == DRAIN_LAST) begin
          fifo_clk_en_d = 1'b0;
          evt_stopped_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_CLK_SW: begin
        req_err_d = start_req | clk_sel_req | stop_req;
        if (cnt_q == CLKSW_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        cnt_d         = '0;
        top_start_d   = 1'b0;
        fifo_clk_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rg_top_start   = top_start_q;
  assign rg_fifo_clk_en = fifo_clk_en_q;
  assign rg_clk_sel     = clk_sel_q;
  assign busy           = busy_q;
  assign state          = state_q;
  assign evt_started    = evt_started_q;
  assign evt_stopped    = evt_stopped_q;
  assign req_err        = req_err_q;

endmodule

// File: tb/tb_top_start_seq.sv
// Directed bench for top_start_seq with hand-computed expectations.
module tb_top_start_seq;

  logic       clk_6p5m_reg = 1'b0;
  logic       rst_reg_n;
  logic       start_req, stop_req, clk_sel_req, clk_sel_val;
  logic       rg_top_start, rg_fifo_clk_en, rg_clk_sel, busy;
  logic [2:0] state;
  logic       evt_started, evt_stopped, req_err;

  int n_cmp = 0;
  int n_err = 0;

  top_start_seq #(
    .CNT_W(12), .FIFO_LEAD(8), .DRAIN_CYC(16), .CLKSW_CYC(1024)
  ) dut (
    .clk_6p5m_reg  (clk_6p5m_reg),
    .rst_reg_n     (rst_reg_n),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .clk_sel_req   (clk_sel_req),
    .clk_sel_val   (clk_sel_val),
    .rg_top_start  (rg_top_start),
    .rg_fifo_clk_en(rg_fifo_clk_en),
    .rg_clk_sel    (rg_clk_sel),
    .busy          (busy),
    .state         (state),
    .evt_started   (evt_started),
    .evt_stopped   (evt_stopped),
    .req_err       (req_err)
  );

  always #5 clk_6p5m_reg = ~clk_6p5m_reg;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_6p5m_reg);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_top"},  rg_top_start,   1'b0);
    chk({tag, "_fifo"}, rg_fifo_clk_en, 1'b0);
    chk({tag, "_sel"},  rg_clk_sel,     1'b0);
    chk({tag, "_busy"}, busy,           1'b0);
    chk_st({tag, "_state"}, state,      3'd0);
    chk({tag, "_evs"},  evt_started,    1'b0);
    chk({tag, "_evp"},  evt_stopped,    1'b0);
    chk({tag, "_err"},  req_err,        1'b0);
  endtask

  // Top must never run without its FIFO clock.
  always @(negedge clk_6p5m_reg) begin
    if (rst_reg_n === 1'b1 && rg_top_start === 1'b1)
      chk("inv_top_implies_fifo", rg_fifo_clk_en, 1'b1);
  end

  initial begin
    rst_reg_n = 1'b0;
    start_req = 1'b0; stop_req = 1'b0; clk_sel_req = 1'b0; clk_sel_val = 1'b0;
    step(3);
    chk_all_zero("reset");
    rst_reg_n = 1'b1;
    step(2);
    chk_all_zero("idle_after_reset");

    // Start: FIFO clock leads top start by 8 edges.
    start_req = 1'b1; step(1); start_req = 1'b0;
    chk("start_fifo_on", rg_fifo_clk_en, 1'b1);
    chk("start_top_low", rg_top_start, 1'b0);
    chk_st("start_state", state, 3'd1);
    chk("start_busy", busy, 1'b1);
    step(7);
    chk("lead7_top_low", rg_top_start, 1'b0);
    chk_st("lead7_state", state, 3'd1);
    step(1);
    chk("lead8_top_high", rg_top_start, 1'b1);
    chk("lead8_evt_started", evt_started, 1'b1);
    chk_st("lead8_state", state, 3'd2);
    step(1);
    chk("evt_started_pulse", evt_started, 1'b0);

    // Illegal clock-select in RUN.
    clk_sel_val = 1'b1; clk_sel_req = 1'b1; step(1); clk_sel_req = 1'b0;
    chk("run_sel_err", req_err, 1'b1);
    chk("run_sel_unchanged", rg_clk_sel, 1'b0);
    chk_st("run_sel_state", state, 3'd2);
    step(1);
    chk("run_sel_err_pulse", req_err, 1'b0);

    // Stop: FIFO drains 16 edges after top falls.
    stop_req = 1'b1; step(1); stop_req = 1'b0;
    chk("stop_top_low", rg_top_start, 1'b0);
    chk("stop_fifo_still", rg_fifo_clk_en, 1'b1);
    chk_st("stop_state", state, 3'd3);
    step(15);
    chk("drain15_fifo", rg_fifo_clk_en, 1'b1);
    chk_st("drain15_state", state, 3'd3);
    step(1);
    chk("drain16_fifo_off", rg_fifo_clk_en, 1'b0);
    chk("drain16_evt_stopped", evt_stopped, 1'b1);
    chk_st("drain16_state", state, 3'd0);
    chk("drain16_busy", busy, 1'b0);

    // Back-to-back start, then abort 3 cycles into FIFO_ON.
    start_req = 1'b1; step(1); start_req = 1'b0;
    chk_st("b2b_state", state, 3'd1);
    chk("b2b_evt_stopped_cleared", evt_stopped, 1'b0);
    step(2);
    stop_req = 1'b1; step(1); stop_req = 1'b0;
    chk("abort_fifo_off", rg_fifo_clk_en, 1'b0);
    chk_st("abort_state", state, 3'd0);
    chk("abort_no_evt", evt_stopped, 1'b0);
    chk("abort_no_err", req_err, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("abort_top_never", rg_top_start, 1'b0);
      chk("abort_no_evt_later", evt_stopped, 1'b0);
    end

    // Clock switch to CLKIN with 1024-cycle settle window.
    clk_sel_val = 1'b1; clk_sel_req = 1'b1; step(1); clk_sel_req = 1'b0;
    chk("sw_sel", rg_clk_sel, 1'b1);
    chk_st("sw_state", state, 3'd4);
    chk("sw_busy", busy, 1'b1);
    chk("sw_no_err", req_err, 1'b0);
    step(5);
    clk_sel_val = 1'b0; clk_sel_req = 1'b1; step(1); clk_sel_req = 1'b0;
    chk("sw_second_err", req_err, 1'b1);
    chk("sw_second_sel_kept", rg_clk_sel, 1'b1);
    step(1017);
    chk("sw_1023_busy", busy, 1'b1);
    chk_st("sw_1023_state", state, 3'd4);
    step(1);
    chk("sw_1024_busy", busy, 1'b0);
    chk_st("sw_1024_state", state, 3'd0);
    chk("sw_1024_sel", rg_clk_sel, 1'b1);

    // Same-value select in IDLE is a silent no-op.
    clk_sel_val = 1'b1; clk_sel_req = 1'b1; step(1); clk_sel_req = 1'b0;
    chk_st("same_sel_state", state, 3'd0);
    chk("same_sel_no_err", req_err, 1'b0);
    chk("same_sel_val", rg_clk_sel, 1'b1);

    // start + clk_sel (different value) together: select wins, start flagged.
    clk_sel_val = 1'b0; clk_sel_req = 1'b1; start_req = 1'b1; step(1);
    clk_sel_req = 1'b0; start_req = 1'b0;
    chk_st("combo_state", state, 3'd4);
    chk("combo_err", req_err, 1'b1);
    chk("combo_sel", rg_clk_sel, 1'b0);
    chk("combo_fifo_off", rg_fifo_clk_en, 1'b0);
    step(1);
    chk("combo_err_pulse", req_err, 1'b0);
    step(1023);
    chk_st("combo_back_idle", state, 3'd0);

    // start + stop in IDLE: stop wins as a no-op, start flagged.
    start_req = 1'b1; stop_req = 1'b1; step(1);
    start_req = 1'b0; stop_req = 1'b0;
    chk_st("ss_state", state, 3'd0);
    chk("ss_err", req_err, 1'b1);
    chk("ss_fifo_off", rg_fifo_clk_en, 1'b0);

    // Set CLKIN, run, enter DRAIN, then reset asynchronously mid-drain.
    clk_sel_val = 1'b1; clk_sel_req = 1'b1; step(1); clk_sel_req = 1'b0;
    step(1024);
    chk_st("pre_rst_idle", state, 3'd0);
    chk("pre_rst_sel", rg_clk_sel, 1'b1);
    start_req = 1'b1; step(1); start_req = 1'b0;
    step(8);
    chk_st("pre_rst_run", state, 3'd2);
    stop_req = 1'b1; step(1); stop_req = 1'b0;
    step(4);
    chk_st("pre_rst_drain", state, 3'd3);
    #2 rst_reg_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(2);
    chk_all_zero("held_rst");
    rst_reg_n = 1'b1;
    step(1);
    chk_all_zero("post_rst");

    start_req = 1'b1; step(1); start_req = 1'b0;
    chk("rerun_fifo", rg_fifo_clk_en, 1'b1);
    step(7);
    chk("rerun_top_low", rg_top_start, 1'b0);
    step(1);
    chk("rerun_top_high", rg_top_start, 1'b1);
    chk("rerun_evt_started", evt_started, 1'b1);
    chk_st("rerun_state", state, 3'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
